// File: rtl/sort_job_arbiter_pkg.sv
// Shared types for the sorter job arbiter: array shapes and scheduler states.
package sort_pkg;

    localparam int SORT_DEPTH = 8;

    typedef logic [7:0] sort_word_t;
    typedef sort_word_t sort_array_t [SORT_DEPTH];

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SORT,
        RESP
    } sched_state_t;

endpackage

// File: rtl/sort_job_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first request above the pointer wins.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    grant_idx_o,
    output logic               any_grant_o
);

    int idx;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_grant_o = 1'b0;
        idx         = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(ptr_i) + i) % NUM_REQ;
            if (!any_grant_o && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                grant_idx_o  = ID_W'(idx);
                any_grant_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sort_job_arbiter.sv
// Shares one linear sorter among NUM_REQ requesters: grant, load, sort, respond.
module sort_job_arbiter
    import sort_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int TIMEOUT = 31,
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_valid,
    input  sort_array_t        req_array [NUM_REQ],
    output logic [NUM_REQ-1:0] req_ready,
    output logic               sorter_reset,
    output sort_array_t        sorter_mixed_array,
    input  sort_array_t        sorter_sorted_array,
    input  logic               sorter_ready,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [ID_W-1:0]    resp_id,
    output sort_array_t        resp_array,
    output logic               resp_error,
    output logic               busy
);

    sched_state_t      state_q;
    logic [ID_W-1:0]   rr_q;
    logic [ID_W-1:0]   job_id_q;
    logic [7:0]        cnt_q;
    logic [7:0]        cnt_d;
    sort_array_t       mixed_q;
    sort_array_t       resp_array_q;
    logic              resp_valid_q;
    logic [ID_W-1:0]   resp_id_q;
    logic              resp_error_q;
    logic              sorter_reset_q;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               any_grant;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req_i       (req_valid),
        .ptr_i       (rr_q),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .any_grant_o (any_grant)
    );

    assign cnt_d = cnt_q + 8'd1;

    // Accept is a same-cycle pulse; suppressed while reset is applied.
    assign req_ready = (state_q == IDLE && !reset) ? grant : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            rr_q           <= ID_W'(NUM_REQ - 1);
            job_id_q       <= '0;
            cnt_q          <= '0;
            mixed_q        <= '{default: '0};
            resp_array_q   <= '{default: '0};
            resp_valid_q   <= 1'b0;
            resp_id_q      <= '0;
            resp_error_q   <= 1'b0;
            sorter_reset_q <= 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (any_grant) begin
                        mixed_q  <= req_array[grant_idx];
                        job_id_q <= grant_idx;
                        rr_q     <= grant_idx;
                        state_q  <= LOAD;
                    end
                end
                LOAD: begin
                    cnt_q          <= '0;
                    sorter_reset_q <= 1'b0;
                    state_q        <= SORT;
                end
                SORT: begin
                    cnt_q <= cnt_d;
                    // A result arriving on the timeout cycle still counts as done.
                    if (sorter_ready || cnt_d == 8'(TIMEOUT)) begin
                        if (sorter_ready) begin
                            resp_array_q <= sorter_sorted_array;
                            resp_error_q <= 1'b0;
                        end else begin
                            resp_array_q <= '{default: '0};
                            resp_error_q <= 1'b1;
                        end
                        resp_id_q      <= job_id_q;
                        resp_valid_q   <= 1'b1;
                        sorter_reset_q <= 1'b1;
                        state_q        <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sorter_reset       = sorter_reset_q;
    assign sorter_mixed_array = mixed_q;
    assign resp_valid         = resp_valid_q;
    assign resp_id            = resp_id_q;
    assign resp_array         = resp_array_q;
    assign resp_error         = resp_error_q;
    assign busy               = (state_q != IDLE);

endmodule

// File: tb/tb_sort_job_arbiter.sv
// Directed bench for sort_job_arbiter with a behavioural sorter stub.
module tb_sort_job_arbiter;
    import sort_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int TIMEOUT = 31;

    logic               clk = 1'b0;
    logic               reset;
    logic [NUM_REQ-1:0] req_valid;
    sort_array_t        req_array [NUM_REQ];
    logic [NUM_REQ-1:0] req_ready;
    logic               sorter_reset;
    sort_array_t        mixed;
    sort_array_t        sorted;
    logic               sorter_ready;
    logic               resp_valid;
    logic               resp_ready;
    logic [1:0]         resp_id;
    sort_array_t        resp_array;
    logic               resp_error;
    logic               busy;

    int checks = 0;
    int errors = 0;

    sort_job_arbiter #(
        .NUM_REQ (NUM_REQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .req_valid           (req_valid),
        .req_array           (req_array),
        .req_ready           (req_ready),
        .sorter_reset        (sorter_reset),
        .sorter_mixed_array  (mixed),
        .sorter_sorted_array (sorted),
        .sorter_ready        (sorter_ready),
        .resp_valid          (resp_valid),
        .resp_ready          (resp_ready),
        .resp_id             (resp_id),
        .resp_array          (resp_array),
        .resp_error          (resp_error),
        .busy                (busy)
    );

    always #5 clk = ~clk;

    // Sorter stub: ready on SORT cycle stub_delay (0 = never), ascending order.
    int          stub_delay = 9;
    int          scnt;
    sort_array_t stub_t;
    logic [7:0]  stub_tmp;

    always @(posedge clk) begin
        if (sorter_reset) scnt <= 0;
        else scnt <= scnt + 1;
    end

    assign sorter_ready = !sorter_reset && stub_delay != 0
                          && scnt == stub_delay - 1;

    always_comb begin
        stub_t   = mixed;
        stub_tmp = '0;
        for (int i = 0; i < 7; i++) begin
            for (int j = 0; j < 7 - i; j++) begin
                if (stub_t[j] > stub_t[j+1]) begin
                    stub_tmp    = stub_t[j];
                    stub_t[j]   = stub_t[j+1];
                    stub_t[j+1] = stub_tmp;
                end
            end
        end
    end

    assign sorted = stub_t;

    // Grant monitor.
    int gcnt [NUM_REQ] = '{default: 0};
    int gorder [$];
    int busy_grant = 0;

    always @(posedge clk) begin
        if (!reset) begin
            if (busy && req_ready != '0) busy_grant <= busy_grant + 1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i]) begin
                    gcnt[i] <= gcnt[i] + 1;
                    gorder.push_back(i);
                end
            end
        end
    end

    function automatic logic [63:0] pk(input sort_array_t a);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = a[i];
        return r;
    endfunction

    function automatic sort_array_t mk(input logic [63:0] v);
        sort_array_t r;
        for (int i = 0; i < 8; i++) r[i] = v[8*i +: 8];
        return r;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_resp(input int max, output int n, output int sc);
        n  = 0;
        sc = 0;
        while (!resp_valid && n < max) begin
            tick();
            n++;
            if (!sorter_reset) sc++;
        end
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        req_valid  = '0;
        resp_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (busy !== 1'b0 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state busy=%b resp_valid=%b want 0 0",
                     busy, resp_valid);
        end
        checks++;
        if (sorter_reset !== 1'b1 || resp_error !== 1'b0 || resp_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_outs srst=%b err=%b id=%0d want 1 0 0",
                     sorter_reset, resp_error, resp_id);
        end
        checks++;
        if (pk(mixed) !== 64'h0 || pk(resp_array) !== 64'h0 || req_ready !== 4'b0) begin
            errors++;
            $display("FAIL reset_arrays mixed=%h resp=%h rdy=%b want zeros",
                     pk(mixed), pk(resp_array), req_ready);
        end
    endtask

    task automatic test_single();
        int n, sc, base;
        base         = gcnt[0];
        stub_delay   = 9;
        req_array[0] = mk(64'h04_06_02_07_01_08_03_05);
        req_valid    = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL single_accept req_ready=%b want 0001", req_ready);
        end
        tick();
        req_valid = '0;
        wait_resp(50, n, sc);
        checks++;
        if (!resp_valid || n != 10 || sc != 9) begin
            errors++;
            $display("FAIL single_latency valid=%b n=%0d sort=%0d want 1 10 9",
                     resp_valid, n, sc);
        end
        checks++;
        if (resp_id !== 2'd0 || resp_error !== 1'b0) begin
            errors++;
            $display("FAIL single_id id=%0d err=%b want 0 0", resp_id, resp_error);
        end
        checks++;
        if (pk(resp_array) !== 64'h08_07_06_05_04_03_02_01) begin
            errors++;
            $display("FAIL single_array got=%h want 0807060504030201",
                     pk(resp_array));
        end
        checks++;
        if (gcnt[0] - base != 1) begin
            errors++;
            $display("FAIL single_pulses got=%0d want 1", gcnt[0] - base);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_release valid=%b busy=%b want 0 0",
                     resp_valid, busy);
        end
    endtask

    task automatic test_round_robin();
        int base, bg, n;
        int exp_ord [5] = '{0, 1, 2, 3, 0};
        do_reset();
        base = gorder.size();
        bg   = busy_grant;
        for (int i = 0; i < NUM_REQ; i++)
            req_array[i] = mk(64'h10_20_30_40_50_60_70_80 + 64'(i));
        resp_ready = 1'b1;
        req_valid  = 4'b1111;
        n = 0;
        while (gorder.size() - base < 5 && n < 200) begin
            tick();
            n++;
        end
        req_valid = '0;
        checks++;
        if (gorder.size() - base < 5) begin
            errors++;
            $display("FAIL rr_count got=%0d want 5", gorder.size() - base);
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (gorder[base+k] != exp_ord[k]) begin
                    errors++;
                    $display("FAIL rr_order[%0d] got=%0d want %0d",
                             k, gorder[base+k], exp_ord[k]);
                end
            end
        end
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        resp_ready = 1'b0;
        checks++;
        if (busy_grant != bg || busy !== 1'b0) begin
            errors++;
            $display("FAIL rr_busy_grant got=%0d busy=%b want 0 0",
                     busy_grant - bg, busy);
        end
    endtask

    task automatic test_timeout();
        int n, sc;
        stub_delay   = 0;
        req_array[1] = mk(64'h11_22_33_44_55_66_77_88);
        req_valid    = 4'b0010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL to_accept req_ready=%b want 0010", req_ready);
        end
        tick();
        req_valid = '0;
        wait_resp(100, n, sc);
        checks++;
        if (!resp_valid || sc != 31) begin
            errors++;
            $display("FAIL to_cycles valid=%b sort=%0d want 1 31", resp_valid, sc);
        end
        checks++;
        if (resp_error !== 1'b1 || pk(resp_array) !== 64'h0 || resp_id !== 2'd1) begin
            errors++;
            $display("FAIL to_resp err=%b arr=%h id=%0d want 1 0 1",
                     resp_error, pk(resp_array), resp_id);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready   = 1'b0;
        stub_delay   = 9;
        req_array[1] = mk(64'h40_01_07_07_80_FF_00_09);
        req_valid    = 4'b0010;
        tick();
        req_valid = '0;
        wait_resp(50, n, sc);
        checks++;
        if (!resp_valid || resp_error !== 1'b0
            || pk(resp_array) !== 64'hFF_80_40_09_07_07_01_00) begin
            errors++;
            $display("FAIL to_recover valid=%b err=%b arr=%h want 1 0 ff80400907070100",
                     resp_valid, resp_error, pk(resp_array));
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int n, sc, bad, rdy2;
        logic [63:0] arr0;
        logic [1:0]  id0;
        req_array[1] = mk(64'h01_02_03_04_05_06_07_08);
        req_valid    = 4'b0010;
        tick();
        req_valid = '0;
        wait_resp(50, n, sc);
        arr0 = pk(resp_array);
        id0  = resp_id;
        checks++;
        if (!resp_valid || arr0 !== 64'h08_07_06_05_04_03_02_01 || id0 !== 2'd1) begin
            errors++;
            $display("FAIL bp_first valid=%b arr=%h id=%0d want 1 0807060504030201 1",
                     resp_valid, arr0, id0);
        end
        req_array[2] = mk(64'h09_08_07_06_05_04_03_02);
        req_valid    = 4'b0100;
        bad  = 0;
        rdy2 = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!resp_valid || pk(resp_array) !== arr0 || resp_id !== id0) bad++;
            if (req_ready[2]) rdy2++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_stable unstable_cycles=%0d want 0", bad);
        end
        checks++;
        if (rdy2 != 0) begin
            errors++;
            $display("FAIL bp_no_grant ready_cycles=%0d want 0", rdy2);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL bp_release valid=%b busy=%b rdy=%b want 0 0 0100",
                     resp_valid, busy, req_ready);
        end
        tick();
        req_valid = '0;
        wait_resp(50, n, sc);
        checks++;
        if (!resp_valid || resp_id !== 2'd2
            || pk(resp_array) !== 64'h09_08_07_06_05_04_03_02) begin
            errors++;
            $display("FAIL bp_second valid=%b id=%0d arr=%h want 1 2 0908070605040302",
                     resp_valid, resp_id, pk(resp_array));
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n, seen;
        req_array[1] = mk(64'h33_33_22_22_11_11_00_00);
        req_valid    = 4'b0010;
        tick();
        req_valid = '0;
        n = 0;
        while (sorter_reset && n < 20) begin
            tick();
            n++;
        end
        tick();
        tick();
        checks++;
        if (sorter_reset !== 1'b0 || !busy) begin
            errors++;
            $display("FAIL mid_in_sort srst=%b busy=%b want 0 1", sorter_reset, busy);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || resp_valid !== 1'b0 || sorter_reset !== 1'b1
            || resp_id !== 2'd0 || resp_error !== 1'b0) begin
            errors++;
            $display("FAIL mid_outs busy=%b valid=%b srst=%b id=%0d err=%b want 0 0 1 0 0",
                     busy, resp_valid, sorter_reset, resp_id, resp_error);
        end
        checks++;
        if (pk(mixed) !== 64'h0 || pk(resp_array) !== 64'h0) begin
            errors++;
            $display("FAIL mid_arrays mixed=%h resp=%h want 0 0",
                     pk(mixed), pk(resp_array));
        end
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (resp_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL mid_dropped resp_valid_cycles=%0d want 0", seen);
        end
        req_array[0] = mk(64'h00_00_00_00_00_00_00_05);
        req_array[2] = mk(64'h00_00_00_00_00_00_00_06);
        req_valid    = 4'b0101;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL mid_pointer req_ready=%b want 0001", req_ready);
        end
        tick();
        req_valid = '0;
        wait_resp(50, n, seen);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic test_tie();
        int n, sc;
        stub_delay   = 31;
        req_array[3] = mk(64'h01_03_06_0C_19_32_64_C8);
        req_valid    = 4'b1000;
        tick();
        req_valid = '0;
        wait_resp(100, n, sc);
        checks++;
        if (!resp_valid || sc != 31 || resp_error !== 1'b0) begin
            errors++;
            $display("FAIL tie_status valid=%b sort=%0d err=%b want 1 31 0",
                     resp_valid, sc, resp_error);
        end
        checks++;
        if (pk(resp_array) !== 64'hC8_64_32_19_0C_06_03_01 || resp_id !== 2'd3) begin
            errors++;
            $display("FAIL tie_array arr=%h id=%0d want c86432190c060301 3",
                     pk(resp_array), resp_id);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        stub_delay = 9;
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = '0;
        resp_ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) req_array[i] = '{default: '0};
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        test_tie();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
